// File: rtl/conv_pkg.sv
// Shared FSM state type and padding constants for the convolution frame sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAD_TOP    = 3'd1,
        ROW        = 3'd2,
        PAD_BOTTOM = 3'd3,
        FINISH     = 3'd4
    } conv_seq_state_t;

    localparam int KERNEL_ROW_DEFAULT = 3;
    localparam int KERNEL_COL_DEFAULT = 3;
    localparam int PR = (KERNEL_ROW_DEFAULT - 1) / 2;
    localparam int PC = (KERNEL_COL_DEFAULT - 1) / 2;

    // Zero padding needed on each side of an odd kernel dimension.
    function automatic int pad_of(input int kernel_size);
        return (kernel_size - 1) / 2;
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Position inside the padded frame: the column wraps at i_col_last and carries into the row.
module conv_pos_counter #(
    parameter int COL_W = 11,
    parameter int ROW_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [COL_W-1:0] i_col_last,
    input  logic [ROW_W-1:0] i_row_last,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_col_wrap,
    output logic             o_frame_end
);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_col_wrap  = (r_col == i_col_last);
    assign o_frame_end = o_col_wrap && (r_row == i_row_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_advance) begin
            // The last element parks the counters at the origin rather than rolling into a new frame.
            if (o_frame_end) begin
                r_col <= '0;
                r_row <= '0;
            end else if (o_col_wrap) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams a source frame into the conv line buffer, wrapping it in zero padding in raster order
// and flagging elements that complete a window centred on a real pixel.
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH         = 8,
    parameter int BUFFER_LENGTH      = 2000,
    parameter int KERNEL_ROW_SIZE    = 2 * PR + 1,
    parameter int KERNEL_COLUMN_SIZE = 2 * PC + 1,
    localparam int CW                = $clog2(BUFFER_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CW-1:0]         frame_column_size,
    input  logic [CW-1:0]         frame_row_size,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] buf_point,
    output logic                  buf_valid,
    output logic [CW-1:0]         buf_col_size,
    output logic                  window_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int ROW_PAD = pad_of(KERNEL_ROW_SIZE);
    localparam int COL_PAD = pad_of(KERNEL_COLUMN_SIZE);
    localparam int RW      = CW + 1;
    localparam logic [RW-1:0] MAX_COLS = RW'(BUFFER_LENGTH - 2 * COL_PAD);

    conv_seq_state_t       r_state;
    conv_seq_state_t       w_next_state;
    logic [CW-1:0]         r_cols;
    logic [CW-1:0]         r_rows;
    logic [CW-1:0]         r_buf_col_size;
    logic [DATA_WIDTH-1:0] r_buf_point;
    logic                  r_buf_valid;
    logic                  r_window_valid;
    logic                  r_done;

    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_col_wrap;
    logic          w_frame_end;
    logic [CW-1:0] w_col_last;
    logic [RW-1:0] w_row_last;
    logic [RW-1:0] w_top_last;
    logic [RW-1:0] w_body_last;
    logic          w_pixel_col;
    logic          w_accept;
    logic          w_size_ok;
    logic          w_window;
    logic          w_s_ready;
    logic          w_emit;
    logic          w_take;

    assign w_col_last  = r_cols + CW'(2 * COL_PAD) - CW'(1);
    assign w_row_last  = {1'b0, r_rows} + RW'(2 * ROW_PAD) - RW'(1);
    assign w_top_last  = RW'(ROW_PAD) - RW'(1);
    assign w_body_last = {1'b0, r_rows} + RW'(ROW_PAD) - RW'(1);
    assign w_pixel_col = (w_col >= CW'(COL_PAD)) && (w_col < r_cols + CW'(COL_PAD));

    // A start in the done cycle is still inside the busy window and is dropped.
    assign w_accept  = (r_state == IDLE) && !r_done && start;
    assign w_size_ok = (frame_row_size != '0) && (frame_column_size != '0)
                       && ({1'b0, frame_column_size} <= MAX_COLS);
    assign w_window  = w_emit && (w_row >= RW'(KERNEL_ROW_SIZE - 1))
                       && (w_col >= CW'(KERNEL_COLUMN_SIZE - 1));

    conv_pos_counter #(
        .COL_W (CW),
        .ROW_W (RW)
    ) u_pos_counter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_accept),
        .i_advance   (w_emit),
        .i_col_last  (w_col_last),
        .i_row_last  (w_row_last),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_col_wrap  (w_col_wrap),
        .o_frame_end (w_frame_end)
    );

    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_emit       = 1'b0;
        w_take       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_size_ok)        w_next_state = FINISH;
                    else if (ROW_PAD == 0) w_next_state = ROW;
                    else                   w_next_state = PAD_TOP;
                end
            end
            PAD_TOP: begin
                w_emit = 1'b1;
                if (w_col_wrap && (w_row == w_top_last)) w_next_state = ROW;
            end
            ROW: begin
                // Side padding is free-running; pixel columns stall until the source delivers.
                w_s_ready = w_pixel_col;
                w_take    = w_pixel_col && s_valid;
                w_emit    = !w_pixel_col || s_valid;
                if (w_emit && w_col_wrap && (w_row == w_body_last))
                    w_next_state = (ROW_PAD == 0) ? FINISH : PAD_BOTTOM;
            end
            PAD_BOTTOM: begin
                w_emit = 1'b1;
                if (w_frame_end) w_next_state = FINISH;
            end
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cols         <= '0;
            r_rows         <= '0;
            r_buf_col_size <= '0;
            r_buf_point    <= '0;
            r_buf_valid    <= 1'b0;
            r_window_valid <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_done         <= (r_state == FINISH);
            r_buf_valid    <= w_emit;
            r_buf_point    <= w_take ? s_data : '0;
            r_window_valid <= w_window;
            if (w_accept) begin
                r_cols         <= frame_column_size;
                r_rows         <= frame_row_size;
                r_buf_col_size <= frame_column_size + CW'(KERNEL_COLUMN_SIZE - 1);
            end
        end
    end

    assign s_ready      = w_s_ready;
    assign buf_point    = r_buf_point;
    assign buf_valid    = r_buf_valid;
    assign buf_col_size = r_buf_col_size;
    assign window_valid = r_window_valid;
    assign busy         = (r_state != IDLE) || r_done;
    assign done         = r_done;

endmodule
